// File: rtl/soc_pkg.sv
// soc_pkg: owner encoding, default bus widths and the 2-way round-robin pick
// shared by the data-memory arbiter.
package soc_pkg;
   localparam int DEF_AW = 32;
   localparam int DEF_DW = 32;
   typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} owner_t;
   // Returns 1 when master 1 should win; a tie goes to the master that was not last.
   function automatic logic rr_pick(input logic last, input logic r0, input logic r1);
      return (r0 & r1) ? ~last : r1;
   endfunction
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-master arbiter for the single data-memory port,
// with per-tenure hold limit, ownership lock and a CPU stall indication.
import soc_pkg::*;
module dmem_arbiter #(
   parameter int MAX_HOLD = 8,
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m0_lock,
   output logic          m0_gnt,
   output logic          m0_stall,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   input  logic          m1_lock,
   output logic          m1_gnt,
   output logic          m1_stall,
   output logic [DW-1:0] m1_rdata,
   output logic          s_ce,
   output logic          s_we,
   output logic [AW-1:0] s_addr,
   output logic [DW-1:0] s_wdata,
   input  logic [DW-1:0] s_rdata
);
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   owner_t owner, nextOwner;
   logic last, nextLast;
   logic [7:0] holdCnt, nextHold;
   always_ff @(posedge clk) begin
      if (rst) begin
         owner <= IDLE;
         last <= 1'b1;
         holdCnt <= '0;
      end else begin
         owner <= nextOwner;
         last <= nextLast;
         holdCnt <= nextHold;
      end
   end
   always_comb begin
      nextOwner = owner;
      nextLast = last;
      case (owner)
         IDLE: if (m0_req | m1_req) nextOwner = rr_pick(last, m0_req, m1_req) ? OWN1 : OWN0;
         OWN0: if (!m0_req || (m1_req && !m0_lock && holdCnt == HOLD_LAST)) begin
            nextOwner = m1_req ? OWN1 : IDLE;
            nextLast = 1'b0;
         end
         OWN1: if (!m1_req || (m0_req && !m1_lock && holdCnt == HOLD_LAST)) begin
            nextOwner = m0_req ? OWN0 : IDLE;
            nextLast = 1'b1;
         end
         default: nextOwner = IDLE;
      endcase
      // Staying in OWNx implies the owner transferred this cycle.
      nextHold = (nextOwner != owner || nextOwner == IDLE) ? 8'd0 :
                 (holdCnt == HOLD_LAST) ? holdCnt : holdCnt + 8'd1;
   end
   assign m0_gnt = (owner == OWN0);
   assign m1_gnt = (owner == OWN1);
   assign m0_stall = m0_req & ~m0_gnt;
   assign m1_stall = m1_req & ~m1_gnt;
   // A transfer coinciding with the reset edge is suppressed so it cannot write.
   assign s_ce = ~rst & (m0_gnt ? m0_req : m1_gnt ? m1_req : 1'b0);
   assign s_we = ~rst & (m0_gnt ? m0_req & m0_we : m1_gnt ? m1_req & m1_we : 1'b0);
   assign s_addr = m0_gnt ? m0_addr : m1_gnt ? m1_addr : '0;
   assign s_wdata = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : '0;
   assign m0_rdata = m0_gnt ? s_rdata : '0;
   assign m1_rdata = m1_gnt ? s_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of grant order, hold limit, lock, reset and
// idle return against a behavioural data memory.
module tb_dmem_arbiter;
   logic clk = 1'b0, rst = 1'b1, memClr = 1'b1;
   logic m0_req = 0, m0_we = 0, m0_lock = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
   logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
   logic m0_gnt, m0_stall, m1_gnt, m1_stall, s_ce, s_we;
   logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata;
   logic [31:0] mem [256];
   int tests = 0, fails = 0;
   always #5 clk = ~clk;
   dmem_arbiter #(.MAX_HOLD(8), .AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_stall(m0_stall), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_stall(m1_stall), .m1_rdata(m1_rdata),
      .s_ce(s_ce), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata)
   );
   always_ff @(posedge clk) begin
      if (memClr) for (int i = 0; i < 256; i++) mem[i] <= '0;
      else if (s_ce && s_we) mem[s_addr[7:0]] <= s_wdata;
   end
   assign s_rdata = mem[s_addr[7:0]];
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   initial begin
      @(negedge clk);
      tick();
      memClr = 1'b0;
      #1;
      chk("rst_m0_gnt", 32'(m0_gnt), 0);
      chk("rst_m1_gnt", 32'(m1_gnt), 0);
      chk("rst_s_ce", 32'(s_ce), 0);
      chk("rst_stall", 32'({m0_stall, m1_stall}), 0);
      @(negedge clk);
      rst = 0;
      m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hA5A5A5A5;
      #1;
      chk("c3_m0_stall", 32'(m0_stall), 1);
      chk("c3_m0_gnt", 32'(m0_gnt), 0);
      chk("c3_s_ce", 32'(s_ce), 0);
      tick(); #1;
      chk("c4_m0_gnt", 32'(m0_gnt), 1);
      chk("c4_m0_stall", 32'(m0_stall), 0);
      chk("c4_ce_we", 32'({s_ce, s_we}), 32'h3);
      chk("c4_s_addr", s_addr, 32'h10);
      chk("c4_s_wdata", s_wdata, 32'hA5A5A5A5);
      tick();
      m0_we = 0; #1;
      chk("rd_m0_rdata", m0_rdata, 32'hA5A5A5A5);
      chk("rd_m1_rdata", m1_rdata, 0);
      chk("rd_s_we", 32'(s_we), 0);
      m0_req = 0; #1;
      chk("drop_s_ce", 32'(s_ce), 0);
      tick(); #1;
      chk("idle_m0_gnt", 32'(m0_gnt), 0);
      chk("idle_s_addr", s_addr, 0);
      chk("idle_s_wdata", s_wdata, 0);
      chk("idle_m0_rdata", m0_rdata, 0);
      // Fresh reset so the first contest is decided by the reset value of last.
      rst = 1;
      tick();
      rst = 0;
      m0_req = 1; m1_req = 1; m1_addr = 32'h20; #1;
      chk("both_idle_stalls", 32'({m0_stall, m1_stall}), 32'h3);
      tick(); #1;
      chk("contest_m0_gnt", 32'(m0_gnt), 1);
      chk("contest_m1_gnt", 32'(m1_gnt), 0);
      chk("contest_m1_stall", 32'(m1_stall), 1);
      tick();
      m0_req = 0; #1;
      chk("m0drop_s_ce", 32'(s_ce), 0);
      tick(); #1;
      chk("handover_m1_gnt", 32'(m1_gnt), 1);
      chk("handover_m0_gnt", 32'(m0_gnt), 0);
      chk("handover_s_addr", s_addr, 32'h20);
      m0_req = 1;
      for (int i = 0; i < 32; i++) begin
         #1;
         chk($sformatf("fair_m1_gnt_%0d", i), 32'(m1_gnt), 32'(((i / 8) % 2) == 0));
         chk($sformatf("fair_m0_gnt_%0d", i), 32'(m0_gnt), 32'(((i / 8) % 2) == 1));
         chk($sformatf("fair_s_ce_%0d", i), 32'(s_ce), 1);
         tick();
      end
      m1_lock = 1;
      for (int i = 0; i < 20; i++) begin
         #1;
         chk($sformatf("lock_m1_gnt_%0d", i), 32'(m1_gnt), 1);
         chk($sformatf("lock_m0_stall_%0d", i), 32'(m0_stall), 1);
         tick();
      end
      m1_lock = 0; #1;
      chk("unlock_m1_gnt", 32'(m1_gnt), 1);
      tick(); #1;
      chk("unlock_m0_gnt", 32'(m0_gnt), 1);
      chk("unlock_m1_stall", 32'(m1_stall), 1);
      m0_req = 0;
      tick();
      m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'h1234; #1;
      chk("pre_rst_m1_gnt", 32'(m1_gnt), 1);
      chk("pre_rst_s_we", 32'(s_we), 1);
      rst = 1; #1;
      chk("in_rst_s_we", 32'(s_we), 0);
      tick();
      rst = 0; m1_we = 0; m1_req = 0; m1_addr = 0; #1;
      chk("post_rst_gnts", 32'({m0_gnt, m1_gnt}), 0);
      chk("post_rst_s_ce", 32'(s_ce), 0);
      chk("post_rst_mem40", mem[8'h40], 0);
      m0_req = 1; m1_req = 1;
      tick(); #1;
      chk("post_rst_contest_m0", 32'(m0_gnt), 1);
      chk("post_rst_contest_m1", 32'(m1_gnt), 0);
      m0_req = 0; m1_req = 0;
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter that shares the single data-memory port between the CPU load/store path (master 0) and a second bus master such as a DMA or debug loader (master 1).
- Sits between the memory/IO controller's RAM-side outputs plus the second master, and the DataMem instance.
- Grants are registered and use round-robin priority. A per-tenure hold limit enforces fairness, and a lock input keeps ownership across multi-word sequences.
- Supplies a stall indication so the CPU can freeze while it waits for the port.

Parameters:
- MAX_HOLD, 8, maximum transfers one master may perform per tenure while the other master is requesting (unlocked); legal range 1..255.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- m0_req  in  1  CPU access request (one transfer per cycle while granted)
- m0_we  in  1  CPU write enable
- m0_addr  in  AW  CPU address
- m0_wdata  in  DW  CPU write data
- m0_lock  in  1  CPU holds ownership past MAX_HOLD
- m0_gnt  out  1  CPU owns the port
- m0_stall  out  1  m0_req & ~m0_gnt
- m0_rdata  out  DW  read data to CPU
- m1_req, m1_we, m1_addr, m1_wdata, m1_lock, m1_gnt, m1_rdata  same as the m0_* ports, for master 1
- s_ce  out  1  DataMem chip enable
- s_we  out  1  DataMem write enable
- s_addr  out  AW  DataMem address
- s_wdata  out  DW  DataMem write data
- s_rdata  in  DW  DataMem read data (combinational read)

Behaviour:
- State register owner ∈ {IDLE, OWN0, OWN1}.
  - m0_gnt = (owner==OWN0); m1_gnt = (owner==OWN1). Both are registered, never both 1.
- Reset (synchronous, may occur at any cycle):
  - owner=IDLE, last=1 (master 0 wins the first contest), hold_cnt=0.
  - Effect appears at the first edge with rst=1. Any in-flight transfer in that cycle is dropped and no write occurs after the edge.
  - Output values while in IDLE:
    - m0_gnt=0, m1_gnt=0, s_ce=0, s_we=0, s_addr=0, s_wdata=0, m0_rdata=0, m1_rdata=0.
    - m0_stall and m1_stall track their req inputs.
- Slave mux (combinational from owner):
  - OWNx: s_ce=mx_req, s_we=mx_req&mx_we, s_addr=mx_addr, s_wdata=mx_wdata, mx_rdata=s_rdata.
  - The non-owner's rdata is 0.
  - IDLE drives zeros on all slave outputs.
- Transfer: one word per cycle in which mx_gnt & mx_req are both 1. A write commits at that clock edge.
- Grant latency: request raised in cycle N while IDLE gives gnt=1 in cycle N+1. The first transfer happens in cycle N+1.
- Transitions, evaluated each edge:
  - IDLE:
    - Both req → grant the master ≠ last.
    - One req → grant it.
    - No req → stay IDLE.
  - OWNx, own req=0:
    - Other req=1 → OWNother.
    - Otherwise → IDLE.
    - last=x in both cases.
  - OWNx, own req=1, other req=1, mx_lock=0, hold_cnt==MAX_HOLD-1 → OWNother, last=x. The transfer in this cycle completes first.
  - OWNx, otherwise → stay.
- hold_cnt:
  - Increments on each transfer by the owner, saturating at MAX_HOLD-1.
  - Clears on any ownership change or entry to IDLE.
- Lock:
  - Lock asserted → the owner keeps the port indefinitely while it requests.
  - Lock is ignored by a non-owner.
  - Dropping req ends the tenure regardless of lock.
- Handover: there is no dead cycle between OWN0 and OWN1. The new owner's transfer happens in the cycle after the old owner's last transfer.
- Simultaneous req in the same cycle from IDLE is resolved by last only.
- A master that deasserts req while waiting loses nothing: no grant is issued unless req is high at the decision edge.

Decomposition:
- Shared package (soc_pkg): owner state encoding constants (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and default AW/DW widths.
- No sub-module is needed. The optional rr_pick function (2-way round-robin select) lives in the package.

Test Plan:
- Reset then single CPU request:
  - Stimulus: rst for 2 cycles, then m0_req=1, m0_we=1, addr=0x10, wdata=0xA5A5A5A5 from cycle 3.
  - Response: m0_gnt=1 in cycle 4, s_ce=s_we=1, s_addr=0x10. A subsequent read of 0x10 returns 0xA5A5A5A5 on m0_rdata. m0_stall=1 only in cycle 3.
- Simultaneous first contest:
  - Stimulus: m0_req and m1_req both rise from IDLE after reset.
  - Response: m0_gnt first. After m0 drops req, m1_gnt=1 on the next cycle with no IDLE gap.
- Fairness with MAX_HOLD=8:
  - Stimulus: both masters request continuously, locks low.
  - Response: ownership alternates every 8 transfers. s_ce stays high every cycle. Exactly 8 consecutive transfers per tenure.
- Lock:
  - Stimulus: m1 owns with m1_lock=1 for 20 cycles while m0 requests.
  - Response: m1 performs 20 consecutive transfers and m0_stall=1 throughout. When m1_lock falls, the grant moves to m0 at the next hold-limit boundary or when m1_req drops.
- Reset mid-burst:
  - Stimulus: rst=1 during an m1 write to 0x40 with data 0x1234.
  - Response: after that edge all grants are 0 and s_ce=0. The next contest grants m0 first.
- Idle return:
  - Stimulus: the single owner drops req.
  - Response: owner=IDLE next cycle and all slave outputs read 0.
